obj_affine_fetch: RTL and testbench

OBJ_AFFINE_FETCH -- requirements
Module: obj_affine_fetch

---
 rtl/obj_affine_fetch.sv | 177 +++++++++++++++++
 tb/tb_obj_affine_fetch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/obj_affine_fetch.sv
// Affine OBJ line fetch: walks render columns, reads OBJ tile VRAM, writes line buffer.
// Ports: clock/reset, start + sprite params, col/x/y to rot-scale, vram_*, lb_*, busy/done. Option: OBJ_1D_MAP_EN.
module obj_affine_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  objx,
  input  logic [7:0]  hsize,
  input  logic [7:0]  vsize,
  input  logic        dblsize,
  input  logic        bpp8,
  input  logic        map1d,
  input  logic [9:0]  tile_base,
  input  logic [3:0]  palbank,
  output logic [7:0]  col,
  input  logic [6:0]  x,
  input  logic [6:0]  y,
  output logic        vram_req,
  output logic [13:0] vram_addr,
  input  logic        vram_ack,
  input  logic [15:0] vram_rdata,
  output logic        lb_we,
  output logic [7:0]  lb_addr,
  output logic [7:0]  lb_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, CALC, FETCH, WRITE, DONE
  } state_t;

  typedef struct packed {
    logic [8:0] objx;
    logic [7:0] hsize;
    logic [7:0] vsize;
    logic       dbl;
    logic       bpp8;
    logic       map1d;
    logic [9:0] tbase;
    logic [3:0] pal;
  } prm_t;

  state_t     st, st_n;
  prm_t       prm;
  logic [7:0] i, i_n;
  logic [6:0] xl, yl;
  logic [7:0] pix;
  logic       opq;

  logic [7:0]  width;
  logic [7:0]  i_inc;
  logic        last;
  logic [8:0]  sx;
  logic        skip;
  logic [9:0]  stride;
  logic [9:0]  ty, tx, tile;
  logic [5:0]  inner;
  logic [14:0] boff;
  logic [7:0]  byt;
  logic [3:0]  nib;
  logic [7:0]  pix_n;
  logic        opq_n;

  assign width = prm.dbl ? {prm.hsize[6:0], 1'b0}
                         : prm.hsize;
  assign i_inc = i + 8'd1;
  assign last  = (i_inc == width);
  assign sx    = prm.objx + {1'b0, i};
  assign skip  = (sx >= 9'd240)
              || ({1'b0, x} >= prm.hsize)
              || ({1'b0, y} >= prm.vsize);

`ifdef OBJ_1D_MAP_EN
  logic [9:0] s1d;
  assign s1d    = {5'b0, prm.hsize[7:3]} << prm.bpp8;
  assign stride = prm.map1d ? s1d : 10'd32;
`else
  logic unused_map1d;
  assign unused_map1d = prm.map1d;
  assign stride       = 10'd32;
`endif

  assign ty    = {6'b0, yl[6:3]} * stride;
  assign tx    = prm.bpp8 ? {5'b0, xl[6:3], 1'b0}
                          : {6'b0, xl[6:3]};
  assign tile  = prm.tbase + ty + tx;
  assign inner = prm.bpp8 ? {yl[2:0], xl[2:0]}
                          : {1'b0, yl[2:0], xl[2:1]};
  assign boff  = {tile, 5'b0} + {9'b0, inner};

  assign byt   = boff[0] ? vram_rdata[15:8]
                         : vram_rdata[7:0];
  assign nib   = xl[0] ? byt[7:4] : byt[3:0];
  assign pix_n = prm.bpp8 ? byt : {prm.pal, nib};
  assign opq_n = prm.bpp8 ? (|byt) : (|nib);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st  <= IDLE;
      i   <= '0;
      prm <= '0;
      xl  <= '0;
      yl  <= '0;
      pix <= '0;
      opq <= 1'b0;
    end else begin
      st <= st_n;
      i  <= i_n;
      if (st == IDLE && start) begin
        prm.objx  <= objx;
        prm.hsize <= hsize;
        prm.vsize <= vsize;
        prm.dbl   <= dblsize;
        prm.bpp8  <= bpp8;
        prm.map1d <= map1d;
        prm.tbase <= tile_base;
        prm.pal   <= palbank;
      end
      if (st == CALC && !skip) begin
        xl <= x;
        yl <= y;
      end
      if (st == FETCH && vram_ack) begin
        pix <= pix_n;
        opq <= opq_n;
      end
    end
  end

  always_comb begin
    st_n = st;
    i_n  = i;
    unique case (st)
      IDLE: begin
        if (start) begin
          st_n = CALC;
          i_n  = '0;
        end
      end
      CALC: begin
        if (skip) begin
          i_n  = i_inc;
          st_n = last ? DONE : CALC;
        end else begin
          st_n = FETCH;
        end
      end
      FETCH: begin
        if (vram_ack) st_n = WRITE;
      end
      WRITE: begin
        i_n  = i_inc;
        st_n = last ? DONE : CALC;
      end
      DONE: begin
        st_n = IDLE;
        i_n  = '0;
      end
      default: begin
        st_n = IDLE;
        i_n  = '0;
      end
    endcase
  end

  assign col       = i;
  assign vram_req  = (st == FETCH);
  assign vram_addr = vram_req ? boff[14:1] : '0;
  assign lb_we     = (st == WRITE) && opq;
  assign lb_addr   = lb_we ? sx[7:0] : '0;
  assign lb_data   = lb_we ? pix : '0;
  assign busy      = (st == CALC) || (st == FETCH)
                  || (st == WRITE);
  assign done      = (st == DONE);

endmodule

// File: tb/tb_obj_affine_fetch.sv
// Directed table-driven bench for obj_affine_fetch.
// Responder models VRAM ack latency; checks counts, addresses, pixels, timing, reset.
module tb_obj_affine_fetch;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [8:0]  objx;
  logic [7:0]  hsize, vsize;
  logic        dblsize, bpp8, map1d;
  logic [9:0]  tile_base;
  logic [3:0]  palbank;
  logic [7:0]  col;
  logic [6:0]  x, y;
  logic        vram_req, vram_ack;
  logic [13:0] vram_addr;
  logic [15:0] vram_rdata;
  logic        lb_we, busy, done;
  logic [7:0]  lb_addr, lb_data;

  logic        xmode;
  logic [6:0]  xc, yc;
  int          ack_delay;
  int          wait_cnt;
  int          checks = 0;
  int          errors = 0;

  obj_affine_fetch dut (
    .clock(clock), .reset(reset), .start(start),
    .objx(objx), .hsize(hsize), .vsize(vsize),
    .dblsize(dblsize), .bpp8(bpp8), .map1d(map1d),
    .tile_base(tile_base), .palbank(palbank),
    .col(col), .x(x), .y(y),
    .vram_req(vram_req), .vram_addr(vram_addr),
    .vram_ack(vram_ack), .vram_rdata(vram_rdata),
    .lb_we(lb_we), .lb_addr(lb_addr),
    .lb_data(lb_data), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  assign x = xmode ? xc : col[6:0];
  assign y = yc;

  always @(posedge clock or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else wait_cnt <= vram_req ? wait_cnt + 1 : 0;
  end
  assign vram_ack = vram_req && (wait_cnt == ack_delay);

  typedef struct {
    logic [8:0]  objx;
    logic [7:0]  hs;
    logic [7:0]  vs;
    logic        dbl;
    logic        b8;
    logic        m1d;
    logic [9:0]  tb;
    logic [3:0]  pal;
    logic        xm;
    logic [6:0]  xc;
    logic [6:0]  yc;
    logic [15:0] rd;
    int          dly;
    int          poke;
    int          e_req;
    int          e_wr;
    int          e_cyc;
    int          e_addr;
    int          e_fa;
    int          e_fd;
    int          e_la;
    int          e_ld;
  } vec_t;

  vec_t vt[9];

`ifdef OBJ_1D_MAP_EN
  localparam int A1D = 64;
`else
  localparam int A1D = 512;
`endif

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int k);
    int cyc, nreq, nwr, stab, got;
    int fa, fd, la, ld, faddr;
    logic pr, pa;
    logic [13:0] pad;
    @(posedge clock); #1;
    objx = v.objx; hsize = v.hs; vsize = v.vs;
    dblsize = v.dbl; bpp8 = v.b8; map1d = v.m1d;
    tile_base = v.tb; palbank = v.pal;
    xmode = v.xm; xc = v.xc; yc = v.yc;
    vram_rdata = v.rd; ack_delay = v.dly;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 0; nreq = 0; nwr = 0; stab = 0; got = 0;
    fa = -1; fd = -1; la = -1; ld = -1; faddr = -1;
    pr = 1'b0; pa = 1'b0; pad = '0;
    while (got == 0 && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      if (vram_req && pr && !pa && vram_addr != pad)
        stab++;
      pr = vram_req; pa = vram_ack; pad = vram_addr;
      if (vram_req && vram_ack) begin
        if (nreq == 0) faddr = int'(vram_addr);
        nreq++;
      end
      if (lb_we) begin
        if (nwr == 0) begin
          fa = int'(lb_addr); fd = int'(lb_data);
        end
        la = int'(lb_addr); ld = int'(lb_data);
        nwr++;
      end
      if (done) got = 1;
      if (v.poke != 0 && cyc == 5) begin
        start = 1'b1;
        objx = v.objx + 9'd50;
      end else if (v.poke != 0 && cyc == 6) begin
        start = 1'b0;
        objx = v.objx;
      end
    end
    chk($sformatf("v%0d_done", k), got, 1);
    chk($sformatf("v%0d_cyc", k), cyc, v.e_cyc);
    chk($sformatf("v%0d_nreq", k), nreq, v.e_req);
    chk($sformatf("v%0d_nwr", k), nwr, v.e_wr);
    chk($sformatf("v%0d_stable", k), stab, 0);
    if (v.e_req > 0)
      chk($sformatf("v%0d_addr", k), faddr, v.e_addr);
    if (v.e_wr > 0) begin
      chk($sformatf("v%0d_fa", k), fa, v.e_fa);
      chk($sformatf("v%0d_fd", k), fd, v.e_fd);
      chk($sformatf("v%0d_la", k), la, v.e_la);
      chk($sformatf("v%0d_ld", k), ld, v.e_ld);
    end
    @(negedge clock);
    chk($sformatf("v%0d_done_pulse", k), int'(done), 0);
    chk($sformatf("v%0d_busy_end", k), int'(busy), 0);
  endtask

  initial begin
    int n, nw, nd;
    reset = 1'b1; start = 1'b0;
    objx = '0; hsize = 8'd8; vsize = 8'd8;
    dblsize = 0; bpp8 = 0; map1d = 0;
    tile_base = '0; palbank = '0;
    xmode = 0; xc = '0; yc = '0;
    vram_rdata = '0; ack_delay = 0;

    vt[0] = '{10, 8, 8, 0, 0, 0, 0, 3, 0, 0, 0, 16'h2100,
              0, 0, 8, 4, 25, 0, 12, 'h31, 17, 'h32};
    vt[1] = '{236, 8, 8, 0, 0, 0, 0, 3, 0, 0, 0, 16'h2100,
              0, 0, 4, 2, 17, 0, 238, 'h31, 239, 'h32};
    vt[2] = '{0, 8, 8, 0, 0, 0, 0, 0, 1, 70, 0, 16'h2100,
              0, 0, 0, 0, 9, 0, 0, 0, 0, 0};
    vt[3] = '{0, 16, 8, 0, 1, 0, 4, 7, 1, 9, 0, 16'h5A00,
              0, 0, 16, 16, 49, 96, 0, 'h5A, 15, 'h5A};
    vt[4] = '{5, 32, 16, 0, 0, 1, 0, 2, 1, 0, 8, 16'h000F,
              0, 0, 32, 32, 97, A1D, 5, 'h2F, 36, 'h2F};
    vt[5] = '{0, 8, 8, 1, 0, 0, 0, 1, 0, 0, 0, 16'h2100,
              0, 0, 8, 4, 33, 0, 2, 'h11, 7, 'h12};
    vt[6] = '{0, 16, 8, 0, 0, 0, 0, 0, 1, 0, 8, 16'h2100,
              0, 0, 0, 0, 17, 0, 0, 0, 0, 0};
    vt[7] = '{508, 8, 8, 0, 0, 0, 0, 3, 0, 0, 0, 16'h2100,
              0, 0, 4, 2, 17, 1, 2, 'h31, 3, 'h32};
    vt[8] = '{20, 8, 8, 0, 0, 0, 0, 4, 1, 1, 0, 16'h0010,
              5, 1, 8, 8, 65, 0, 20, 'h41, 27, 'h41};

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_req", int'(vram_req), 0);
    chk("rst_we", int'(lb_we), 0);
    chk("rst_col", int'(col), 0);
    chk("rst_addr", int'(vram_addr), 0);
    chk("rst_lba", int'(lb_addr), 0);
    chk("rst_lbd", int'(lb_data), 0);
    reset = 1'b0;

    for (int k = 0; k < 9; k++) run(vt[k], k);

    // reset while a fetch is stalled
    @(posedge clock); #1;
    objx = 9'd10; hsize = 8'd8; vsize = 8'd8;
    dblsize = 0; bpp8 = 0; map1d = 0;
    tile_base = '0; palbank = 4'd3;
    xmode = 0; yc = '0; vram_rdata = 16'h2100;
    ack_delay = 100;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (!vram_req && n < 50) begin
      @(negedge clock); n++;
    end
    chk("rf_req_seen", int'(vram_req), 1);
    repeat (2) @(negedge clock);
    chk("rf_req_held", int'(vram_req), 1);
    reset = 1'b1;
    #1;
    chk("rf_req_drop", int'(vram_req), 0);
    chk("rf_busy", int'(busy), 0);
    chk("rf_addr", int'(vram_addr), 0);
    @(negedge clock);
    reset = 1'b0;
    ack_delay = 0;
    nw = 0; nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (lb_we) nw++;
      if (done) nd++;
    end
    chk("rf_no_write", nw, 0);
    chk("rf_no_done", nd, 0);
    chk("rf_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
